// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants and helpers for stream_mux_rr
// Purpose: mode encodings and a width helper shared by the mux, its interface and arbiter.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Channel-index width; never zero so a 1-channel build still has a legal vector.
  function automatic int clog2_min1(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// rtl/stream_mux_rr_if.sv - handshake bundle between producers, the mux and the consumer
// Purpose: groups mode/sel, per-channel input streams and the output stream.
// Ports (slave = mux view): in mode, sel, in_valid, in_data, out_ready;
//                           out in_ready, out_valid, out_data, out_ch.
interface stream_mux_rr_if
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = clog2_min1(N_CH);

  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [N_CH-1:0]          in_valid;
  logic [N_CH*DATA_W-1:0]   in_data;
  logic [N_CH-1:0]          in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rtl/stream_mux_rr_arbiter.sv - combinational rotating-priority arbiter
// Purpose: grant the first requester at or after ptr, wrapping modulo N_CH.
// Ports: req (requests), ptr (highest-priority index) -> gnt_idx, gnt_vld.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [SEL_W:0]    off;
  logic [SEL_W:0]    sum;

  always_comb begin
    // Rotate so that bit 0 of rot is the request at ptr.
    dbl = {req, req} >> ptr;
    rot = dbl[N_CH-1:0];
    off = '0;
    gnt_vld = 1'b0;
    // Walk downward so the smallest offset is the one left standing.
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off     = (SEL_W+1)'(k);
        gnt_vld = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (SEL_W+1)'(N_CH)) begin
      sum = sum - (SEL_W+1)'(N_CH);
    end
    gnt_idx = sum[SEL_W-1:0];
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel stream mux with fixed-select and round-robin modes
// Purpose: picks one valid input stream per cycle into a single registered output.
// Ports: clk, rst_n (sync, active low); bus (slave): mode, sel, in_valid, in_data,
//        in_ready, out_valid, out_data, out_ch, out_ready.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  stream_mux_rr_if.slave bus
);
  localparam int SEL_W = clog2_min1(N_CH);

  logic [SEL_W-1:0]  rr_ptr;
  logic [SEL_W-1:0]  rr_gnt;
  logic              rr_vld;
  logic              fix_vld;
  logic [SEL_W-1:0]  gnt;
  logic              gnt_vld;
  logic              load_en;
  logic [DATA_W-1:0] gnt_data;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [SEL_W-1:0]  out_ch_q;

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (rr_gnt),
    .gnt_vld (rr_vld)
  );

  // Output register can refill in the same cycle it drains.
  assign load_en = !out_valid_q || bus.out_ready;

  always_comb begin
    // sel values past N_CH-1 match no channel and therefore never grant.
    fix_vld = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.sel == SEL_W'(i) && bus.in_valid[i]) fix_vld = 1'b1;
    end
    if (bus.mode == MODE_RR) begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
    end else begin
      gnt     = bus.sel;
      gnt_vld = fix_vld;
    end
  end

  always_comb begin
    bus.in_ready = '0;
    gnt_data     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt == SEL_W'(i)) begin
        bus.in_ready[i] = rst_n && load_en && gnt_vld;
        gnt_data        = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr      <= '0;
    end else if (load_en) begin
      if (gnt_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= gnt_data;
        out_ch_q    <= gnt;
        if (bus.mode == MODE_RR) begin
          rr_ptr <= (gnt == SEL_W'(N_CH - 1)) ? '0 : gnt + SEL_W'(1);
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule
